// File: rtl/fifo_uart_pkg.sv
// Shared types and sizing helpers for the FIFO-to-UART drain.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    FETCH_LO,
    GAP_LO,
    FETCH_HI,
    TX_START,
    TX_DATA,
    TX_STOP
  } state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int NIBBLE_WIDTH   = 4;

  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART 8N1 serialiser: one load pulse sends a whole frame, done pulses at the end of the stop bit.
module uart_tx_core
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic [UART_DATA_BITS-1:0] byte_i,
  output logic                      tx_o,
  output logic                      tick_o,
  output logic                      last_data_o,
  output logic                      done_o
);

  localparam int                CNT_W          = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST       = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        SLOT_LAST_DATA = 4'(UART_DATA_BITS);
  localparam logic [3:0]        SLOT_STOP      = 4'(UART_DATA_BITS + 1);

  // slot 0 is the start bit, slots 1..8 carry data LSB first, slot 9 is the stop bit
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [3:0]                slot_q, slot_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      active_q, active_d;

  assign tick_o      = active_q && (cnt_q == CNT_LAST);
  assign last_data_o = (slot_q == SLOT_LAST_DATA);
  assign done_o      = tick_o && (slot_q == SLOT_STOP);
  assign tx_o        = tx_q;

  always_comb begin
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    active_d = active_q;
    if (load_i) begin
      shift_d  = byte_i;
      tx_d     = 1'b0;
      cnt_d    = '0;
      slot_d   = '0;
      active_d = 1'b1;
    end else if (tick_o) begin
      cnt_d = '0;
      if (slot_q == SLOT_STOP) begin
        active_d = 1'b0;
      end else begin
        slot_d = slot_q + 4'd1;
      end
      if (slot_q < SLOT_LAST_DATA) begin
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
      end else begin
        tx_d = 1'b1;
      end
    end else if (active_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      slot_q   <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops nibble pairs from a first-word-fall-through FIFO and ships each packed byte as a UART frame.
// A started byte always finishes; enable only gates the first-nibble fetch.
module fifo_uart_drain
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT     = 104,
  parameter bit LOW_NIBBLE_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    fifo_empty,
  input  logic [NIBBLE_WIDTH-1:0] fifo_data,
  output logic                    fifo_pop,
  output logic                    tx,
  output logic                    busy
);

  state_e                    state_q, state_d;
  logic [NIBBLE_WIDTH-1:0]   first_q, first_d;
  logic                      load;
  logic [UART_DATA_BITS-1:0] packed_byte;
  logic                      tick;
  logic                      last_data;
  logic                      done;

  assign packed_byte = LOW_NIBBLE_FIRST ? {fifo_data, first_q} : {first_q, fifo_data};
  assign busy        = (state_q != FETCH_LO);

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      FETCH_LO: begin
        if (enable && !fifo_empty) begin
          fifo_pop = 1'b1;
          first_d  = fifo_data;
          state_d  = GAP_LO;
        end
      end
      // lets the FIFO's registered empty flag catch up with the first pop
      GAP_LO:   state_d = FETCH_HI;
      FETCH_HI: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          state_d  = TX_START;
        end
      end
      TX_START: if (tick)              state_d = TX_DATA;
      TX_DATA:  if (tick && last_data) state_d = TX_STOP;
      TX_STOP:  if (done)              state_d = FETCH_LO;
      default:                         state_d = FETCH_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_LO;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .byte_i     (packed_byte),
    .tx_o       (tx),
    .tick_o     (tick),
    .last_data_o(last_data),
    .done_o     (done)
  );

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain with a FIFO model, a UART frame monitor and an expected-byte scoreboard.
module tb_fifo_uart_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_data = 4'h0;
  logic       fifo_pop;
  logic       tx;
  logic       busy;

  always #5 clk = ~clk;

  fifo_uart_drain #(
    .CLKS_PER_BIT    (CPB),
    .LOW_NIBBLE_FIRST(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .busy      (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         fall_q[$];
  int         pop_cyc_q[$];
  int         cyc_n = 0;
  int         pop_cnt = 0;
  int         frames = 0;
  logic       pop_s = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 4'h0 : fifo_q[0];
  endfunction

  task automatic push_nib(input logic [3:0] n);
    fifo_q.push_back(n);
    fifo_refresh();
  endtask

  function automatic logic [39:0] frame_wave(input logic [7:0] b);
    logic [39:0] w;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = i / CPB;
      if (k == 0)      w[i] = 1'b0;
      else if (k == 9) w[i] = 1'b1;
      else             w[i] = b[k-1];
    end
    return w;
  endfunction

  always @(posedge clk) cyc_n++;

  // FIFO model: pop request sampled well before the edge, read pointer advances just after it
  always begin
    @(negedge clk);
    #3;
    pop_s = fifo_pop;
  end

  always begin
    @(posedge clk);
    #1;
    if (pop_s && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
      pop_cyc_q.push_back(cyc_n);
    end
    pop_s = 1'b0;
    fifo_refresh();
  end

  // Frame monitor: captures 40 samples from the falling start edge and compares the whole waveform
  logic [39:0] smp = '0;
  int          mon_n = 0;
  bit          mon_on = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (tx === 1'b0) begin
        mon_on = 1'b1;
        smp    = '0;
        mon_n  = 1;
        fall_q.push_back(cyc_n);
      end
    end else begin
      smp[mon_n] = tx;
      mon_n++;
      if (mon_n == 10 * CPB) begin
        mon_on = 1'b0;
        frames++;
        chk("frame_expected_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("frame", smp, frame_wave(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_tx_low(input int budget);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_tx_low", tx, 1'b0);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      step(1);
      n++;
    end
    chk("wait_frames", 64'(frames >= target), 64'd1);
  endtask

  initial begin
    int p0, fr0, f0, t0, n;

    // 1: reset and idle
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("reset_outputs", {tx, fifo_pop, busy}, 3'b100);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_outputs", {tx, fifo_pop, busy}, 3'b100);
    end

    // 2: single byte with both nibbles ready
    p0 = pop_cnt;
    exp_q.push_back(8'h5A);
    push_nib(4'hA);
    push_nib(4'h5);
    enable = 1'b1;
    wait_tx_low(20);
    chk("busy_at_start", busy, 1'b1);
    t0 = cyc_n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step(1);
      n++;
    end
    chk("busy_span", 64'(cyc_n - t0), 64'd40);
    chk("pops_byte1", 64'(pop_cnt - p0), 64'd2);
    if (pop_cyc_q.size() >= 2)
      chk("pop_gap", 64'(pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[pop_cyc_q.size()-2]), 64'd2);
    wait_frames(1, 20);

    // 3: second nibble arrives late
    p0 = pop_cnt;
    push_nib(4'h3);
    step(5);
    chk("stall_one_pop", 64'(pop_cnt - p0), 64'd1);
    for (int i = 0; i < 45; i++) begin
      step(1);
      chk("stall_tx_busy", {tx, busy}, 2'b11);
    end
    exp_q.push_back(8'hC3);
    push_nib(4'hC);
    wait_frames(2, 100);
    chk("stall_two_pops", 64'(pop_cnt - p0), 64'd2);

    // 4: back-to-back bytes
    p0 = pop_cnt;
    f0 = fall_q.size();
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h65);
    for (int i = 1; i <= 6; i++) push_nib(4'(i));
    wait_frames(5, 250);
    chk("b2b_pops", 64'(pop_cnt - p0), 64'd6);
    chk("b2b_falls", 64'(fall_q.size() - f0), 64'd3);
    if (fall_q.size() - f0 >= 3) begin
      chk("b2b_spacing_1", 64'(fall_q[f0+1] - fall_q[f0]), 64'd43);
      chk("b2b_spacing_2", 64'(fall_q[f0+2] - fall_q[f0+1]), 64'd43);
    end

    // 5: enable gating
    step(5);
    enable = 1'b0;
    p0 = pop_cnt;
    fr0 = frames;
    push_nib(4'h7);
    push_nib(4'h8);
    step(10);
    chk("disabled_no_pop", 64'(pop_cnt - p0), 64'd0);
    chk("disabled_idle", {tx, busy}, 2'b10);
    exp_q.push_back(8'h87);
    enable = 1'b1;
    wait_tx_low(20);
    step(8);
    enable = 1'b0;
    push_nib(4'h6);
    push_nib(4'h9);
    wait_frames(fr0 + 1, 100);
    step(20);
    chk("drop_enable_pops", 64'(pop_cnt - p0), 64'd2);
    chk("drop_enable_frames", 64'(frames - fr0), 64'd1);
    chk("drop_enable_idle", busy, 1'b0);

    // 6: reset in the middle of data bit 3
    p0 = pop_cnt;
    fr0 = frames;
    exp_q.push_back(8'h96);
    enable = 1'b1;
    wait_tx_low(20);
    step(17);
    chk("bit3_before_reset", tx, 1'b0);
    enable = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1'b1);
    chk("async_reset_busy", busy, 1'b0);
    exp_q.delete();
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("reset_pops", 64'(pop_cnt - p0), 64'd2);
    chk("aborted_frame", 64'(frames - fr0), 64'd0);
    exp_q.push_back(8'hCB);
    push_nib(4'hB);
    push_nib(4'hC);
    enable = 1'b1;
    wait_frames(fr0 + 1, 100);
    step(5);
    chk("post_reset_pops", 64'(pop_cnt - p0), 64'd4);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
